prbs_checker_multi: RTL and testbench

Parametrised, multi-polynomial successor to the single-pattern PRBS31 checker. Sits at the receive end of the BER tester behind the data register stage. Each enabled cycle it takes one WIDTH-bit word and self-synchronises to the incoming PRBS7/15/23/31 stream (optionally inverted). Once locked it free-runs its own LFSR, so one line error gives one error count, not the error multiplication a self-synchronising checker produces. It also keeps saturating BER accumulators for software.

---
 rtl/prbs_checker_multi.sv | 179 +++++++++++++++++
 tb/tb_prbs_checker_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker_multi.sv
// Multi-polynomial PRBS checker (PRBS7/15/23/31, optionally inverted).
// Self-synchronises to the received stream. Once locked, it free-runs its own LFSR.
// Also keeps saturating error/word accumulators.
module prbs_checker_multi #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           prbs,
  input  logic [1:0]                 mode,
  input  logic                       inv,
  input  logic                       clr_cnt,
  output logic                       lock,
  output logic                       valid,
  output logic [$clog2(WIDTH+1)-1:0] err_num,
  output logic [CNT_W-1:0]           err_total,
  output logic [CNT_W-1:0]           word_total
);

  localparam int unsigned EW = $clog2(WIDTH + 1);
  localparam int unsigned LW = $clog2(LOCK_CNT + 1);
  localparam int unsigned RW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SW = ((CNT_W > EW) ? CNT_W : EW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [30:0]      hist, hist_nxt, hist_pred, hist_rx;
  logic [LW-1:0]    good_run, good_nxt;
  logic [RW-1:0]    bad_run, bad_nxt;
  logic [1:0]       last_mode;
  logic             last_inv, have_cfg;
  logic [4:0]       tap_a, tap_b, deg;
  logic [30:0]      deg_mask;
  logic [WIDTH-1:0] pred, rx, mismatch;
  logic [EW-1:0]    err_c;
  logic             qualified, cfg_change, acc;
  logic [SW-1:0]    err_sum;

  // Tap positions (history index, 0 = newest) and degree for the selected polynomial
  always_comb begin
    tap_a = 5'd27;
    tap_b = 5'd30;
    deg   = 5'd31;
    case (mode)
      2'b00: begin tap_a = 5'd5;  tap_b = 5'd6;  deg = 5'd7;  end
      2'b01: begin tap_a = 5'd13; tap_b = 5'd14; deg = 5'd15; end
      2'b10: begin tap_a = 5'd17; tap_b = 5'd22; deg = 5'd23; end
      default: begin tap_a = 5'd27; tap_b = 5'd30; deg = 5'd31; end
    endcase
    deg_mask = 31'((32'd1 << deg) - 32'd1);
  end

  // Unrolled LFSR prediction, received-history shift, and mismatch popcount
  always_comb begin
    logic [30:0] tp;
    logic [30:0] tr;
    logic        nb;
    tp    = hist;
    tr    = hist;
    nb    = 1'b0;
    pred  = '0;
    rx    = prbs ^ {WIDTH{inv}};
    err_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nb                = tp[tap_a] ^ tp[tap_b];
      pred[WIDTH-1-i]   = nb;
      tp                = {tp[29:0], nb};
      tr                = {tr[29:0], rx[WIDTH-1-i]};
    end
    hist_pred = tp;
    hist_rx   = tr;
    mismatch  = prbs ^ pred ^ {WIDTH{inv}};
    for (int i = 0; i < WIDTH; i++) begin
      err_c = err_c + EW'(mismatch[i]);
    end
  end

  assign qualified  = |(hist & deg_mask);
  assign cfg_change = have_cfg && ((mode != last_mode) || (inv != last_inv));
  assign acc        = en && !cfg_change && (state == LOCKED);
  assign err_sum    = SW'(err_total) + SW'(err_c);

  // Next-state logic: search/lock decisions and history update
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    good_nxt  = good_run;
    bad_nxt   = bad_run;
    if (en) begin
      if (cfg_change) begin
        state_nxt = SEARCH;
        hist_nxt  = hist_rx;
        good_nxt  = '0;
        bad_nxt   = '0;
      end else if (state == SEARCH) begin
        hist_nxt = hist_rx;
        bad_nxt  = '0;
        if (qualified && (err_c == '0)) begin
          if (good_run == LW'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_run + LW'(1);
          end
        end else begin
          good_nxt = '0;
        end
      end else begin
        hist_nxt = hist_pred;
        if (err_c != '0) begin
          if (bad_run == RW'(UNLOCK_CNT - 1)) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            bad_nxt = bad_run + RW'(1);
          end
        end else begin
          bad_nxt = '0;
        end
      end
    end
  end

  // State, history, run counters and last configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      last_mode <= 2'b00;
      last_inv  <= 1'b0;
      have_cfg  <= 1'b0;
      lock      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      good_run <= good_nxt;
      bad_run  <= bad_nxt;
      lock     <= (state_nxt == LOCKED);
      if (en) begin
        last_mode <= mode;
        last_inv  <= inv;
        have_cfg  <= 1'b1;
      end
    end
  end

  // Per-word report and saturating accumulators (clear wins over accumulation)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      err_num    <= '0;
      err_total  <= '0;
      word_total <= '0;
    end else begin
      valid <= en;
      if (en) begin
        err_num <= err_c;
      end
      if (clr_cnt) begin
        err_total  <= '0;
        word_total <= '0;
      end else if (acc) begin
        err_total  <= (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
        word_total <= (word_total == CNT_MAX) ? CNT_MAX : word_total + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker_multi.sv
// Directed self-checking bench for prbs_checker_multi. A second instance uses CNT_W=4 to exercise saturation.
module tb_prbs_checker_multi;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, en, inv, clr_cnt;
  logic [W-1:0] prbs;
  logic [1:0]   mode;
  logic         lock, valid;
  logic [3:0]   err_num;
  logic [31:0]  err_total, word_total;
  logic         s_lock, s_valid;
  logic [3:0]   s_err_num, s_err_total, s_word_total;

  int total = 0;
  int bad   = 0;
  int nz, vmiss, vbad, lk_seen, lk_drop;

  bit q[$];
  int ta, tb;
  logic [W-1:0] w;

  prbs_checker_multi #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .en(en), .prbs(prbs), .mode(mode), .inv(inv),
    .clr_cnt(clr_cnt), .lock(lock), .valid(valid), .err_num(err_num),
    .err_total(err_total), .word_total(word_total)
  );

  prbs_checker_multi #(.WIDTH(W), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .en(en), .prbs(prbs), .mode(mode), .inv(inv),
    .clr_cnt(clr_cnt), .lock(s_lock), .valid(s_valid), .err_num(s_err_num),
    .err_total(s_err_total), .word_total(s_word_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Bit-serial reference stream: b[n] = b[n-ta] ^ b[n-tb]
  task start_stream(input logic [1:0] m);
    logic [30:0] seed;
    seed = 31'h1A3C96E1;
    case (m)
      2'b00: begin ta = 6;  tb = 7;  end
      2'b01: begin ta = 14; tb = 15; end
      2'b10: begin ta = 18; tb = 23; end
      default: begin ta = 28; tb = 31; end
    endcase
    q.delete();
    for (int i = 30; i >= 0; i--) q.push_back(seed[i]);
  endtask

  task next_word(output logic [W-1:0] o);
    int n;
    bit b;
    for (int i = 0; i < W; i++) begin
      n = q.size();
      b = q[n-ta] ^ q[n-tb];
      q.push_back(b);
      o[W-1-i] = b;
      if (q.size() > 64) void'(q.pop_front());
    end
  endtask

  task drive(input logic [W-1:0] d, input logic c);
    @(negedge clk);
    en = 1'b1; prbs = d; clr_cnt = c;
    @(posedge clk); #1;
    if (valid !== 1'b1) vmiss++;
    if (err_num != 0) nz++;
  endtask

  task idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; clr_cnt = 1'b0;
      @(posedge clk); #1;
      if (valid !== 1'b0) vbad++;
    end
  endtask

  task clean(input int n);
    repeat (n) begin next_word(w); drive(w, 1'b0); end
  endtask

  task gapped(input int n);
    repeat (n) begin next_word(w); drive(w, 1'b0); idle($urandom_range(1, 10)); end
  endtask

  task pulse_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; clr_cnt = 1'b0;
    #1;
    chk("rst_async_lock", lock, 0);
    chk("rst_async_errtot", err_total, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; inv = 1'b0; clr_cnt = 1'b0; prbs = '0; mode = 2'b11;
    #12;
    chk("rst_lock", lock, 0);
    chk("rst_valid", valid, 0);
    chk("rst_errnum", err_num, 0);
    chk("rst_errtot", err_total, 0);
    chk("rst_wordtot", word_total, 0);
    @(negedge clk); reset = 1'b0;

    // Clean PRBS31, en held high
    start_stream(2'b11);
    clean(1);
    chk("p31_w1_nolock", lock, 0);
    clean(20);
    chk("p31_w21_lock", lock, 1);
    next_word(w); drive(w, 1'b1);
    chk("clr_errtot", err_total, 0);
    chk("clr_wordtot", word_total, 0);
    nz = 0; vmiss = 0;
    clean(1000);
    chk("p31_errnum_zero", nz, 0);
    chk("p31_valid_each", vmiss, 0);
    chk("p31_errtot", err_total, 0);
    chk("p31_wordtot", word_total, 1000);
    chk("small_wordtot_sat", s_word_total, 15);
    chk("small_errtot", s_err_total, 0);

    // Single-bit and full-word errors while locked
    next_word(w); drive(w ^ 8'h10, 1'b0);
    chk("err1_num", err_num, 1);
    chk("err1_lock", lock, 1);
    chk("err1_errtot", err_total, 1);
    chk("err1_wordtot", word_total, 1001);
    next_word(w); drive(w ^ 8'hFF, 1'b0);
    chk("err8_num", err_num, 8);
    chk("err8_errtot", err_total, 9);
    chk("err8_lock", lock, 1);
    clean(1);
    chk("after_err_num", err_num, 0);

    // Async reset mid-operation, then gapped enables
    pulse_reset();
    chk("rst_mid_wordtot", word_total, 0);
    start_stream(2'b11);
    vbad = 0; vmiss = 0;
    gapped(21);
    chk("gap_lock", lock, 1);
    next_word(w); drive(w, 1'b1);
    nz = 0;
    gapped(200);
    chk("gap_errnum_zero", nz, 0);
    chk("gap_wordtot", word_total, 200);
    chk("gap_errtot", err_total, 0);
    chk("gap_valid_idle", vbad, 0);
    chk("gap_valid_word", vmiss, 0);

    // Four inverted words drop lock on the fourth, then relock
    next_word(w); drive(w, 1'b1);
    lk_drop = 0;
    repeat (3) begin next_word(w); drive(w ^ 8'hFF, 1'b0); if (!lock) lk_drop++; end
    chk("inv3_still_lock", lk_drop, 0);
    next_word(w); drive(w ^ 8'hFF, 1'b0);
    chk("inv4_unlock", lock, 0);
    chk("inv4_errtot", err_total, 32);
    chk("inv4_wordtot", word_total, 4);
    clean(1);
    chk("relock_w1", lock, 0);
    clean(19);
    chk("relock_w20", lock, 1);
    lk_drop = 0;
    repeat (3) begin next_word(w); drive(w ^ 8'hFF, 1'b0); if (!lock) lk_drop++; end
    clean(1);
    if (!lock) lk_drop++;
    chk("bad3_keeps_lock", lk_drop, 0);

    // All-zero stream never locks; inverted PRBS15 does
    pulse_reset();
    mode = 2'b11; inv = 1'b0;
    lk_seen = 0;
    repeat (200) begin drive('0, 1'b0); if (lock) lk_seen++; end
    chk("zero_nolock", lk_seen, 0);
    mode = 2'b01; inv = 1'b1;
    start_stream(2'b01);
    repeat (21) begin next_word(w); drive(w ^ 8'hFF, 1'b0); end
    chk("p15inv_lock", lock, 1);
    nz = 0;
    repeat (10) begin next_word(w); drive(w ^ 8'hFF, 1'b0); end
    chk("p15inv_errnum", nz, 0);

    // Mode switch PRBS31 -> PRBS7, clear with errored word, saturation
    pulse_reset();
    mode = 2'b11; inv = 1'b0;
    start_stream(2'b11);
    clean(21);
    chk("sw_p31_lock", lock, 1);
    mode = 2'b00;
    start_stream(2'b00);
    clean(1);
    chk("sw_unlock", lock, 0);
    clean(20);
    chk("sw_p7_lock", lock, 1);
    nz = 0;
    clean(10);
    chk("sw_p7_errnum", nz, 0);
    next_word(w); drive(w ^ 8'h01, 1'b1);
    chk("clr_err_num", err_num, 1);
    chk("clr_err_errtot", err_total, 0);
    chk("clr_err_wordtot", word_total, 0);
    repeat (20) begin
      next_word(w); drive(w ^ 8'h04, 1'b0);
      next_word(w); drive(w, 1'b0);
    end
    chk("sat_main_errtot", err_total, 20);
    chk("sat_main_wordtot", word_total, 40);
    chk("sat_small_errtot", s_err_total, 15);
    chk("sat_small_wordtot", s_word_total, 15);
    chk("sat_lock", lock, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
